// File: rtl/sbqm_pkg.sv
// Shared types and constants for the bank queue manager.
package sbqm_pkg;

    // Photocell beam phase: unbroken or broken by a person.
    typedef enum logic {
        CLEAR   = 1'b0,
        BLOCKED = 1'b1
    } sensor_state_t;

    localparam int unsigned DEF_MAX_PEOPLE = 32'd7;
    localparam int unsigned DEF_SERVICE_T  = 32'd3;

    // Legal range of the active-teller count.
    localparam int unsigned TELLER_MIN = 32'd1;
    localparam int unsigned TELLER_MAX = 32'd3;

endpackage

// File: rtl/sbqm_sensor_fsm.sv
// Pairs beam-change pulses from one photocell into whole-person events.
// The first pulse marks the beam broken, the second marks it restored and
// completes the person. The completion event is combinational so the count
// register can act on it at the very next edge. The port is named evt
// because "event" is a reserved word.
module sbqm_sensor_fsm
    import sbqm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic evt
);

    sensor_state_t state_r;

    // Beam phase tracking: every pulse toggles the phase, reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CLEAR;
        end else if (pulse) begin
            case (state_r)
                CLEAR:   state_r <= BLOCKED;
                BLOCKED: state_r <= CLEAR;
                default: state_r <= CLEAR;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign evt = (state_r == BLOCKED) && pulse;

endmodule

// File: rtl/sbqm_queue_ctrl.sv
// Queue controller: turns entry/exit photocell pulses into a people count,
// full/empty flags, overflow/underflow pulses and an estimated wait time.
module sbqm_queue_ctrl
    import sbqm_pkg::*;
#(
    parameter int MAX_PEOPLE = DEF_MAX_PEOPLE,
    parameter int CNT_W      = 3,
    parameter int SERVICE_T  = DEF_SERVICE_T,
    parameter int WT_W       = 5
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             back_pulse,
    input  logic             front_pulse,
    input  logic [1:0]       tcount,
    output logic [CNT_W-1:0] pcount,
    output logic [WT_W-1:0]  wtime,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             cfg_err
);

    localparam int               GW      = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEOPLE);
    localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_1   = CNT_W'(1'b1);
    localparam logic [WT_W-1:0]  SVC     = WT_W'(SERVICE_T);

    // Estimated wait: SERVICE_T minutes per ceil(p / tellers) customers.
    // A zero teller count is treated as one teller. The divisor is at most
    // three, so each case reduces to a constant-divisor expression.
    function automatic logic [WT_W-1:0] wait_minutes(
        input logic [CNT_W-1:0] p,
        input logic [1:0]       t
    );
        logic [GW-1:0] p_ext;
        logic [GW-1:0] groups;
        logic [1:0]    t_eff;
        p_ext = {1'b0, p};
        t_eff = (t < 2'(TELLER_MIN)) ? 2'(TELLER_MIN) : t;
        case (t_eff)
            2'd1:    groups = p_ext;
            2'd2:    groups = (p_ext + GW'(1'b1)) >> 1;
            2'd3:    groups = (p_ext + GW'(2'd2)) / GW'(2'd3);
            default: groups = p_ext;
        endcase
        return WT_W'(groups) * SVC;
    endfunction

    logic             enter_s;
    logic             leave_s;
    logic [CNT_W-1:0] next_cnt_s;
    logic             ovf_s;
    logic             unf_s;

    logic [CNT_W-1:0] pcount_r;
    logic [WT_W-1:0]  wtime_r;
    logic             empty_r;
    logic             full_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             cfg_err_r;

    sbqm_sensor_fsm u_back (
        .clk   (clk),
        .rst   (rst),
        .pulse (back_pulse),
        .evt   (enter_s)
    );

    sbqm_sensor_fsm u_front (
        .clk   (clk),
        .rst   (rst),
        .pulse (front_pulse),
        .evt   (leave_s)
    );

    // Next count and error pulses from the completed enter/leave events;
    // the count saturates at both ends instead of wrapping.
    always_comb begin
        next_cnt_s = pcount_r;
        ovf_s      = 1'b0;
        unf_s      = 1'b0;
        if (enter_s && leave_s) begin
            if (pcount_r == CNT_0) begin
                next_cnt_s = CNT_1;
                unf_s      = 1'b1;
            end else begin
                next_cnt_s = pcount_r;
            end
        end else if (enter_s) begin
            if (pcount_r == CNT_MAX) begin
                ovf_s = 1'b1;
            end else begin
                next_cnt_s = pcount_r + CNT_1;
            end
        end else if (leave_s) begin
            if (pcount_r == CNT_0) begin
                unf_s = 1'b1;
            end else begin
                next_cnt_s = pcount_r - CNT_1;
            end
        end else begin
            next_cnt_s = pcount_r;
        end
    end

    // Count, flags and error pulses, registered together so they agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcount_r    <= CNT_0;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            pcount_r    <= next_cnt_s;
            empty_r     <= (next_cnt_s == CNT_0);
            full_r      <= (next_cnt_s == CNT_MAX);
            overflow_r  <= ovf_s;
            underflow_r <= unf_s;
        end
    end

    // Wait time and teller configuration error, one cycle behind their inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wtime_r   <= {WT_W{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            wtime_r   <= wait_minutes(pcount_r, tcount);
            cfg_err_r <= (tcount == 2'd0);
        end
    end

    assign pcount    = pcount_r;
    assign wtime     = wtime_r;
    assign empty     = empty_r;
    assign full      = full_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// Testbench for sbqm_queue_ctrl: directed scenarios followed by random
// pulses, every cycle compared against a behavioural queue model.
module tb_sbqm_queue_ctrl;

    localparam int MAXP = 7;
    localparam int SVCT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       back_pulse = 1'b0;
    logic       front_pulse = 1'b0;
    logic [1:0] tcount = 2'd1;
    logic [2:0] pcount;
    logic [4:0] wtime;
    logic       empty, full, overflow, underflow, cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: beam phases, people count and expected registered outputs.
    bit m_bblk, m_fblk;
    int m_cnt, m_wt;
    bit m_ov, m_uf, m_cfg;

    sbqm_queue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .back_pulse  (back_pulse),
        .front_pulse (front_pulse),
        .tcount      (tcount),
        .pcount      (pcount),
        .wtime       (wtime),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_ref(input int c, input int t);
        int te;
        te = (t == 0) ? 1 : t;
        if (c == 0) return 0;
        return SVCT * ((c + te - 1) / te);
    endfunction

    // Advance the model by one clock edge using the values just sampled.
    task automatic model_edge(input bit b, input bit f, input int t, input bit r);
        bit enter, leave;
        if (r) begin
            m_bblk = 0; m_fblk = 0; m_cnt = 0; m_wt = 0;
            m_ov = 0; m_uf = 0; m_cfg = 0;
        end else begin
            enter = m_bblk && b;
            leave = m_fblk && f;
            if (b) m_bblk = !m_bblk;
            if (f) m_fblk = !m_fblk;
            m_wt  = wait_ref(m_cnt, t);
            m_cfg = (t == 0);
            m_ov  = 0;
            m_uf  = 0;
            if (enter && leave) begin
                if (m_cnt == 0) begin m_cnt = 1; m_uf = 1; end
            end else if (enter) begin
                if (m_cnt == MAXP) m_ov = 1; else m_cnt++;
            end else if (leave) begin
                if (m_cnt == 0) m_uf = 1; else m_cnt--;
            end
        end
    endtask

    task automatic check_all();
        check_val("pcount", int'(pcount), m_cnt);
        check_val("empty", int'(empty), int'(m_cnt == 0));
        check_val("full", int'(full), int'(m_cnt == MAXP));
        check_val("overflow", int'(overflow), int'(m_ov));
        check_val("underflow", int'(underflow), int'(m_uf));
        check_val("cfg_err", int'(cfg_err), int'(m_cfg));
        check_val("wtime", int'(wtime), m_wt);
    endtask

    task automatic step(input bit b, input bit f, input int t, input bit r);
        back_pulse  = b;
        front_pulse = f;
        tcount      = 2'(t);
        rst         = r;
        @(posedge clk);
        model_edge(b, f, t, r);
        #1;
        check_all();
    endtask

    task automatic person_in(input int t);
        step(1, 0, t, 0);
        step(0, 0, t, 0);
        step(1, 0, t, 0);
        step(0, 0, t, 0);
    endtask

    initial begin
        int t_cur;
        step(0, 0, 1, 1);
        repeat (5) step(0, 0, 1, 0);
        check_val("plan_reset_p", int'(pcount), 0);
        check_val("plan_reset_empty", int'(empty), 1);

        // Three people, then vary the teller count.
        repeat (3) person_in(1);
        step(0, 0, 1, 0);
        check_val("plan_p3", int'(pcount), 3);
        check_val("plan_w9", int'(wtime), 9);
        repeat (2) step(0, 0, 2, 0);
        check_val("plan_w6", int'(wtime), 6);
        repeat (2) step(0, 0, 3, 0);
        check_val("plan_w3", int'(wtime), 3);

        // Fill to capacity, then one more entry.
        repeat (4) person_in(1);
        step(0, 0, 1, 0);
        check_val("plan_full", int'(full), 1);
        check_val("plan_w21", int'(wtime), 21);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        check_val("plan_ovf", int'(overflow), 1);
        check_val("plan_p7", int'(pcount), 7);
        step(0, 0, 1, 0);
        check_val("plan_ovf_1cyc", int'(overflow), 0);

        // Exit pair from empty, then a lone exit pulse.
        step(0, 0, 1, 1);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        check_val("plan_unf", int'(underflow), 1);
        step(0, 1, 1, 0);
        repeat (3) step(0, 0, 1, 0);
        check_val("plan_lone_p0", int'(pcount), 0);

        // Simultaneous completions at 4 and at 0.
        step(0, 0, 1, 1);
        repeat (4) person_in(1);
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        check_val("plan_both_p4", int'(pcount), 4);
        step(0, 0, 1, 1);
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        check_val("plan_both_p1", int'(pcount), 1);
        check_val("plan_both_unf", int'(underflow), 1);

        // Zero tellers with five people.
        step(0, 0, 0, 1);
        repeat (5) person_in(0);
        step(0, 0, 0, 0);
        check_val("plan_cfg_err", int'(cfg_err), 1);
        check_val("plan_w15", int'(wtime), 15);

        // Reset while the back beam is half-seen.
        step(1, 0, 1, 0);
        step(0, 0, 1, 1);
        step(1, 0, 1, 0);
        repeat (2) step(0, 0, 1, 0);
        check_val("plan_rst_half", int'(pcount), 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        check_val("plan_rst_pair", int'(pcount), 1);

        // Random traffic, including held pulses and occasional resets.
        t_cur = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) t_cur = $urandom_range(0, 3);
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 t_cur, ($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sbqm_queue_ctrl.md
Name: sbqm_queue_ctrl

Overview:
Queue controller for the bank queue manager. Consumes the one-cycle change pulses from the back (entry) and front (exit-to-teller) photocell edge detectors. Pairs pulses into whole-person events, keeps the people count, and produces full/empty flags, error pulses and the estimated wait time for the display.
Sits between the two photocell instances and the display/alarm logic.

Parameters:
MAX_PEOPLE, 7, queue capacity in persons (>=1)
CNT_W, 3, width of people count; must hold MAX_PEOPLE
SERVICE_T, 3, minutes per customer per teller
WT_W, 5, wait-time width; must hold SERVICE_T*MAX_PEOPLE

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
back_pulse  in  1  one-cycle pulse from the entry photocell on each beam change (break or restore)
front_pulse  in  1  one-cycle pulse from the exit photocell on each beam change
tcount  in  2  active tellers, valid 1..3
pcount  out  CNT_W  persons currently in queue
wtime  out  WT_W  estimated wait, minutes
empty  out  1  pcount==0
full  out  1  pcount==MAX_PEOPLE
overflow  out  1  one-cycle pulse: entry completed while full
underflow  out  1  one-cycle pulse: exit completed while empty
cfg_err  out  1  level, tcount==0 this cycle

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - pcount=0, wtime=0, empty=1, full=0, overflow=0, underflow=0, cfg_err=0.
  - Both sensor FSMs go to CLEAR.
  - rst overrides all inputs in the same cycle.
  - Reset mid-pairing discards the half-seen person.
- Sensor phase FSM, one per sensor, identical:
  - States: CLEAR (beam unbroken) and BLOCKED (beam broken).
  - CLEAR + pulse -> BLOCKED, no event.
  - BLOCKED + pulse -> CLEAR, raise internal event (enter for back, leave for front) for that cycle.
  - No pulse -> hold state.
- Count update, registered, takes effect the cycle after the completing pulse is sampled:
  - enter only, pcount<MAX -> pcount+1.
  - enter only, full -> pcount held; overflow pulses 1 cycle.
  - leave only, pcount>0 -> pcount-1.
  - leave only, empty -> pcount held; underflow pulses 1 cycle.
  - enter and leave same cycle, 0<pcount -> pcount unchanged (this includes the full case).
  - enter and leave same cycle, pcount==0 -> pcount=1; underflow pulses (leave ignored).
  - No wrap-around, ever.
- Flags:
  - empty and full are registered with pcount and consistent with it every cycle.
  - overflow and underflow never assert in the same cycle.
- Wait time:
  - t = tcount, except t=1 when tcount==0.
  - wtime = 0 if pcount==0.
  - Otherwise wtime = SERVICE_T * ceil(pcount / t) = SERVICE_T*((pcount+t-1) div t).
  - Registered one cycle after pcount (and after tcount) changes.
  - Total latency from completing pulse to wtime: 2 cycles.
- cfg_err: registered copy of (tcount==0), 1-cycle latency.
- Pulses are assumed single-cycle. A pulse held high for N cycles counts as N pulses; the bench checks this literally.

Decomposition:
- Shared package `sbqm_pkg`:
  - sensor state typedef {CLEAR, BLOCKED}.
  - Defaults for MAX_PEOPLE, SERVICE_T.
  - Teller-count constants TELLER_MIN=1 and TELLER_MAX=3.
- Sub-module `sbqm_sensor_fsm`: pulse-pairing FSM with ports clk, rst, pulse, event. Instantiated twice.
- Wait-time arithmetic: a function or small case table inside the top. Divisor only 1..3, so no general divider.

Test Plan:
- Reset, then idle 5 cycles -> pcount=0, empty=1, full=0, wtime=0, no error pulses.
- tcount=1; 3 persons enter (back_pulse pairs) -> pcount=3 one cycle after each 2nd pulse; wtime=9 two cycles after final pulse. Then tcount=2 -> wtime=6 two cycles later; tcount=3 -> wtime=3.
- Fill to 7 with tcount=1 -> full=1, wtime=21. An 8th entry pair -> overflow 1-cycle pulse, pcount stays 7.
- From empty, a front_pulse pair -> underflow pulse, pcount=0. A single lone front_pulse -> no event, FSM BLOCKED.
- pcount=4, back and front completing pulses in the same cycle -> pcount stays 4, no error. At pcount=0 same stimulus -> pcount=1, underflow pulse.
- tcount=0 with pcount=5 -> cfg_err=1, wtime=15. rst asserted with back FSM BLOCKED -> next back pulse only re-blocks; pcount unchanged.
